// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet/ARP constants, TX state type and a helper
//                that extracts MSB-first bytes from a header field.
//  Revision    : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;

    localparam int ETH_MIN_FRAME = 60;
    localparam int ARP_FRAME_LEN = 42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Byte k (0 = most significant) of a field nbytes wide, right-aligned in 48 bits.
    function automatic logic [7:0] field_byte(input logic [47:0] value,
                                              input int unsigned nbytes,
                                              input int unsigned k);
        logic [47:0] sh;
        sh = value >> (8 * (nbytes - 1 - k));
        return sh[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_byte_rom.sv
`default_nettype none
// ============================================================================
//  Module      : arp_byte_rom
//  Description : Combinational index -> byte map of an Ethernet ARP reply,
//                headers through target IP; indices beyond are zero.
//  Revision    : 1.0
// ============================================================================
module arp_byte_rom
    import eth_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h00D0_0800_0002,
    parameter logic [31:0] SRC_IP  = 32'hC0A8_006E
) (
    input  logic [5:0]  i_idx,
    input  logic [47:0] i_dst_mac,
    input  logic [31:0] i_dst_ip,
    output logic [7:0]  o_data
);

    int unsigned w_k;

    always_comb begin
        w_k    = 32'(i_idx);
        o_data = 8'h00;
        if (w_k < 6)
            o_data = field_byte(i_dst_mac, 6, w_k);
        else if (w_k < 12)
            o_data = field_byte(SRC_MAC, 6, w_k - 6);
        else if (w_k < 14)
            o_data = field_byte({32'd0, ETHERTYPE_ARP}, 2, w_k - 12);
        else if (w_k < 16)
            o_data = field_byte({32'd0, ARP_HTYPE_ETH}, 2, w_k - 14);
        else if (w_k < 18)
            o_data = field_byte({32'd0, ARP_PTYPE_IPV4}, 2, w_k - 16);
        else if (w_k == 18)
            o_data = ARP_HLEN_ETH;
        else if (w_k == 19)
            o_data = ARP_PLEN_IPV4;
        else if (w_k < 22)
            o_data = field_byte({32'd0, ARP_OPER_REPLY}, 2, w_k - 20);
        else if (w_k < 28)
            o_data = field_byte(SRC_MAC, 6, w_k - 22);
        else if (w_k < 32)
            o_data = field_byte({16'd0, SRC_IP}, 4, w_k - 28);
        else if (w_k < 38)
            o_data = field_byte(i_dst_mac, 6, w_k - 32);
        else if (w_k < 42)
            o_data = field_byte({16'd0, i_dst_ip}, 4, w_k - 38);
    end

endmodule
`default_nettype wire

// File: rtl/tx_arp.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arp
//  Description : ARP reply transmitter, byte-wide AXI-Stream toward the TX MAC.
//                TX_ARP_PAD_EN defined: 60-byte zero-padded frame; else 42.
//  Revision    : 1.0
// ============================================================================
module tx_arp
    import eth_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC   = 48'h00D0_0800_0002,
    parameter logic [31:0] FPGA_IP    = 32'hC0A8_006E,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST,
    input  logic        TRIG_TX_ARP,
    input  logic [47:0] PC_MAC,
    input  logic [31:0] PC_IP,
    output logic [7:0]  RGMII_TX_DATA,
    output logic        RGMII_TX_VALID,
    output logic        RGMII_TX_LAST,
    output logic        RGMII_TX_USER,
    input  logic        RGMII_TX_READY,
    output logic        TX_ARP_BUSY
);

`ifdef TX_ARP_PAD_EN
    localparam int c_frame_len = ETH_MIN_FRAME;
`else
    localparam int c_frame_len = ARP_FRAME_LEN;
`endif
    localparam logic [5:0] c_last_idx = 6'(c_frame_len - 1);
    localparam logic [7:0] c_gap_end  = 8'(IFG_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [5:0]  r_cnt, w_cnt_next;
    logic [7:0]  r_gap, w_gap_next;
    logic [47:0] r_mac, r_pend_mac, w_mac_next;
    logic [31:0] r_ip, r_pend_ip, w_ip_next;
    logic        r_pending;
    logic [7:0]  r_data, w_rom_data;
    logic        r_last;
    logic        w_take_trig, w_take_pend, w_store_pend;

    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gap_next   = r_gap;
        w_take_trig  = 1'b0;
        w_take_pend  = 1'b0;
        w_store_pend = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (TRIG_TX_ARP) begin
                    w_state_next = SEND;
                    w_cnt_next   = 6'd0;
                    w_take_trig  = 1'b1;
                end
            end
            SEND: begin
                w_store_pend = TRIG_TX_ARP;
                if (RGMII_TX_READY) begin
                    if (r_cnt == c_last_idx) begin
                        w_state_next = GAP;
                        w_gap_next   = 8'd0;
                    end else begin
                        w_cnt_next = r_cnt + 6'd1;
                    end
                end
            end
            GAP: begin
                if (r_gap == c_gap_end) begin
                    w_cnt_next = 6'd0;
                    // A trigger on the last gap cycle is newer than any pending request.
                    if (TRIG_TX_ARP) begin
                        w_state_next = SEND;
                        w_take_trig  = 1'b1;
                    end else if (r_pending) begin
                        w_state_next = SEND;
                        w_take_pend  = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_gap_next   = r_gap + 8'd1;
                    w_store_pend = TRIG_TX_ARP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_mac_next = r_mac;
        w_ip_next  = r_ip;
        if (w_take_trig) begin
            w_mac_next = PC_MAC;
            w_ip_next  = PC_IP;
        end else if (w_take_pend) begin
            w_mac_next = r_pend_mac;
            w_ip_next  = r_pend_ip;
        end
    end

    // Byte for the next cycle is looked up ahead so DATA leaves a register.
    arp_byte_rom #(
        .SRC_MAC (FPGA_MAC),
        .SRC_IP  (FPGA_IP)
    ) u_rom (
        .i_idx     (w_cnt_next),
        .i_dst_mac (w_mac_next),
        .i_dst_ip  (w_ip_next),
        .o_data    (w_rom_data)
    );

    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_cnt      <= 6'd0;
            r_gap      <= 8'd0;
            r_mac      <= 48'd0;
            r_ip       <= 32'd0;
            r_pend_mac <= 48'd0;
            r_pend_ip  <= 32'd0;
            r_pending  <= 1'b0;
            r_data     <= 8'h00;
            r_last     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_gap <= w_gap_next;
            r_mac <= w_mac_next;
            r_ip  <= w_ip_next;
            if (w_store_pend) begin
                r_pend_mac <= PC_MAC;
                r_pend_ip  <= PC_IP;
                r_pending  <= 1'b1;
            end else if (w_take_trig || w_take_pend) begin
                r_pending  <= 1'b0;
            end
            r_data <= (w_state_next == SEND) ? w_rom_data : 8'h00;
            r_last <= (w_state_next == SEND) && (w_cnt_next == c_last_idx);
        end
    end

    always_comb begin
        RGMII_TX_VALID = (r_state == SEND);
        RGMII_TX_DATA  = r_data;
        RGMII_TX_LAST  = r_last;
        RGMII_TX_USER  = 1'b0;
        TX_ARP_BUSY    = (r_state != IDLE) || r_pending;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_arp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_arp
//  Description : Randomized self-checking bench for tx_arp against a
//                frame-level reference model.
//  Revision    : 1.0
// ============================================================================
module tb_tx_arp;

`ifdef TX_ARP_PAD_EN
    localparam int FLEN = 60;
`else
    localparam int FLEN = 42;
`endif
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [47:0] pc_mac;
    logic [31:0] pc_ip;
    logic        ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_user, busy;

    int checks = 0;
    int errors = 0;

    tx_arp #(
        .FPGA_MAC   (48'h00D0_0800_0002),
        .FPGA_IP    (32'hC0A8_006E),
        .IFG_CYCLES (IFG)
    ) dut (
        .CLK_125M       (clk),
        .SYS_RST        (rst),
        .TRIG_TX_ARP    (trig),
        .PC_MAC         (pc_mac),
        .PC_IP          (pc_ip),
        .RGMII_TX_DATA  (tx_data),
        .RGMII_TX_VALID (tx_valid),
        .RGMII_TX_LAST  (tx_last),
        .RGMII_TX_USER  (tx_user),
        .RGMII_TX_READY (ready),
        .TX_ARP_BUSY    (busy)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole reply frame as one big-endian vector; padding zeros appended.
    function automatic logic [7:0] frame_byte(input logic [47:0] mac, input logic [31:0] ip, input int i);
        logic [479:0] f;
        f = {mac, 48'h00D0_0800_0002, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             16'h0002, 48'h00D0_0800_0002, 32'hC0A8_006E, mac, ip, 144'h0};
        return f[479 - 8*i -: 8];
    endfunction

    // Reference: 0 = idle, 1 = sending byte m_idx, 2 = inter-frame gap with m_left cycles to go.
    int          m_phase;
    int          m_idx;
    int          m_left;
    logic [47:0] m_mac, m_pmac;
    logic [31:0] m_ip, m_pip;
    bit          m_pend;
    int          tgl;

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_left = 0; m_pend = 0;
        m_mac = '0; m_ip = '0; m_pmac = '0; m_pip = '0;
    endtask

    task automatic model_start(input logic [47:0] mac, input logic [31:0] ip);
        m_phase = 1; m_idx = 0; m_mac = mac; m_ip = ip;
    endtask

    task automatic model_update(input logic t, input logic [47:0] mac, input logic [31:0] ip, input logic rdy);
        if (m_phase == 0) begin
            if (t) model_start(mac, ip);
        end else if (m_phase == 1) begin
            if (t) begin m_pend = 1; m_pmac = mac; m_pip = ip; end
            if (rdy) begin
                if (m_idx == FLEN - 1) begin m_phase = 2; m_left = IFG; end
                else m_idx++;
            end
        end else begin
            if (m_left == 1) begin
                if (t) begin model_start(mac, ip); m_pend = 0; end
                else if (m_pend) begin model_start(m_pmac, m_pip); m_pend = 0; end
                else m_phase = 0;
            end else begin
                m_left--;
                if (t) begin m_pend = 1; m_pmac = mac; m_pip = ip; end
            end
        end
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'(($urandom % 3) != 0);
        return 1'(tgl % 2 == 0);
    endfunction

    // Called just after a negedge: check outputs, drive next inputs, advance model one clock.
    task automatic tick(input logic t, input logic [47:0] mac, input logic [31:0] ip, input logic rdy);
        check("valid", 64'(tx_valid), 64'(m_phase == 1));
        if (m_phase == 1)
            check("data", 64'(tx_data), 64'(frame_byte(m_mac, m_ip, m_idx)));
        check("last", 64'(tx_last), 64'(m_phase == 1 && m_idx == FLEN - 1));
        check("busy", 64'(busy), 64'(m_phase != 0 || m_pend));
        check("user", 64'(tx_user), 64'd0);
        trig   = t;
        pc_mac = t ? mac : {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        pc_ip  = t ? ip : $urandom;
        ready  = rdy;
        model_update(t, mac, ip, rdy);
        tgl++;
        @(negedge clk);
    endtask

    task automatic idle_tick(input int mode);
        tick(1'b0, 48'd0, 32'd0, pick_ready(mode));
    endtask

    task automatic advance_to_byte(input int k, input int mode);
        bit hit = 0;
        for (int n = 0; n < 500; n++) begin
            if (m_phase == 1 && m_idx == k) begin hit = 1; break; end
            idle_tick(mode);
        end
        if (!hit) check("reach_byte", 64'd0, 64'd1);
    endtask

    task automatic drain(input int mode);
        bit hit = 0;
        for (int n = 0; n < 1000; n++) begin
            if (m_phase == 0 && !m_pend) begin hit = 1; break; end
            idle_tick(mode);
        end
        if (!hit) check("drain", 64'd0, 64'd1);
    endtask

    initial begin
        tgl = 0;
        rst = 1'b1; trig = 1'b0; ready = 1'b1; pc_mac = '0; pc_ip = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_last",  64'(tx_last),  64'd0);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_data",  64'(tx_data),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic reply, READY held high.
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        drain(0);

        // Backpressure: toggling READY then a 5-cycle stall at byte 13.
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        advance_to_byte(13, 2);
        for (int n = 0; n < 5; n++) tick(1'b0, 48'd0, 32'd0, 1'b0);
        drain(2);

        // Trigger during SEND at byte 20.
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        advance_to_byte(20, 0);
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0065, 1'b1);
        drain(0);

        // Two triggers while busy: only the last one is sent.
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        advance_to_byte(10, 1);
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0066, 1'b1);
        advance_to_byte(30, 1);
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0067, 1'b1);
        drain(1);

        // Trigger on the final gap cycle.
        tick(1'b1, 48'hA1A2_A3A4_A5A6, 32'h0A00_0001, 1'b1);
        for (int n = 0; n < 500 && !(m_phase == 2 && m_left == 1); n++) idle_tick(0);
        check("gap_end_reached", 64'(m_phase == 2 && m_left == 1), 64'd1);
        tick(1'b1, 48'hB1B2_B3B4_B5B6, 32'h0A00_0002, 1'b1);
        drain(0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            logic t;
            t = 1'(($urandom % 40) == 0);
            tick(t, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, $urandom, pick_ready(1));
        end
        drain(1);

        // Asynchronous reset mid-frame at byte 25, then a clean frame.
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        advance_to_byte(25, 1);
        #1;
        rst = 1'b1; trig = 1'b0;
        #1;
        check("arst_valid", 64'(tx_valid), 64'd0);
        check("arst_last",  64'(tx_last),  64'd0);
        check("arst_busy",  64'(busy),     64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tick(1'b1, 48'h0011_2233_4455, 32'hC0A8_0064, 1'b1);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
